// File: rtl/regwb_arbiter_if.sv
// regwb_arbiter_if: producer handshakes, register-file write port and
// decode hazard lookup shared by the write-back scheduler and its users.
interface regwb_arbiter_if #(
    parameter int DW = 32
);
    logic          alu_valid;
    logic [3:0]    alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [3:0]    mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          we;
    logic [3:0]    wa;
    logic [DW-1:0] wd;
    logic [3:0]    rd_addr1;
    logic [3:0]    rd_addr2;
    logic          hazard;
    logic          busy;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output rd_addr1, rd_addr2,
        input  alu_ready, mem_ready,
        input  we, wa, wd, hazard, busy
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  rd_addr1, rd_addr2,
        output alu_ready, mem_ready,
        output we, wa, wd, hazard, busy
    );
endinterface

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: two-source write-back scheduler for the register file port.
// Entries drain oldest-first by sequence stamp through a registered stage.
module regwb_arbiter #(
    parameter int DW     = 32,
    parameter int QDEPTH = 2
) (
    input logic            clk,
    input logic            reset,
    regwb_arbiter_if.slave bus
);
    localparam int IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int PW = IW + 1;
    localparam int SW = (QDEPTH <= 2) ? 3 : $clog2(4 * QDEPTH);
    localparam logic [PW-1:0] FULL = PW'(QDEPTH);
    localparam logic [IW-1:0] IMSK = IW'(QDEPTH - 1);
    localparam logic [SW-1:0] HALF = SW'(1 << (SW - 1));

    logic [3:0]    addr_q [2][QDEPTH];
    logic [DW-1:0] data_q [2][QDEPTH];
    logic [SW-1:0] stmp_q [2][QDEPTH];
    logic [PW-1:0] wr_q [2];
    logic [PW-1:0] rd_q [2];
    logic [SW-1:0] seq_q, seq_d;
    logic          we_q, we_d;
    logic [3:0]    wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;

    logic [PW-1:0] cnt [2];
    logic [1:0]    rdy, push, pop, head_v;
    logic [3:0]    in_addr [2];
    logic [DW-1:0] in_data [2];
    logic [SW-1:0] in_stmp [2];
    logic [SW-1:0] head_stmp [2];
    logic          haz;

    function automatic logic [IW-1:0] ix(input logic [PW-1:0] p);
        return p[IW-1:0] & IMSK;
    endfunction

    // Modular age test; valid while at most half the stamp space is in flight.
    function automatic logic older(input logic [SW-1:0] a,
                                   input logic [SW-1:0] b);
        logic [SW-1:0] d;
        d = b - a;
        return (d != '0) && (d <= HALF);
    endfunction

    always_comb begin
        in_addr[0] = bus.alu_addr;
        in_data[0] = bus.alu_data;
        in_addr[1] = bus.mem_addr;
        in_data[1] = bus.mem_data;
        for (int s = 0; s < 2; s++) begin
            cnt[s]       = wr_q[s] - rd_q[s];
            rdy[s]       = (cnt[s] != FULL);
            head_v[s]    = (cnt[s] != '0);
            head_stmp[s] = stmp_q[s][ix(rd_q[s])];
        end
        push[0]    = bus.alu_valid & rdy[0];
        push[1]    = bus.mem_valid & rdy[1];
        in_stmp[0] = seq_q;
        in_stmp[1] = seq_q + SW'(push[0]);
        seq_d      = seq_q + SW'(push[0]) + SW'(push[1]);
        pop[0] = head_v[0] &
                 (~head_v[1] | older(head_stmp[0], head_stmp[1]));
        pop[1] = head_v[1] & ~pop[0];
        we_d = |head_v;
        wa_d = wa_q;
        wd_d = wd_q;
        if (pop[0]) begin
            wa_d = addr_q[0][ix(rd_q[0])];
            wd_d = data_q[0][ix(rd_q[0])];
        end else if (pop[1]) begin
            wa_d = addr_q[1][ix(rd_q[1])];
            wd_d = data_q[1][ix(rd_q[1])];
        end
    end

    always_comb begin
        haz = we_q & ((wa_q == bus.rd_addr1) | (wa_q == bus.rd_addr2));
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < QDEPTH; j++) begin
                if ((PW'(j) < cnt[s]) &&
                    ((addr_q[s][ix(rd_q[s] + PW'(j))] == bus.rd_addr1) ||
                     (addr_q[s][ix(rd_q[s] + PW'(j))] == bus.rd_addr2)))
                    haz = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wr_q[s] <= '0;
                rd_q[s] <= '0;
            end
            seq_q <= '0;
            we_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    addr_q[s][ix(wr_q[s])] <= in_addr[s];
                    data_q[s][ix(wr_q[s])] <= in_data[s];
                    stmp_q[s][ix(wr_q[s])] <= in_stmp[s];
                    wr_q[s] <= wr_q[s] + PW'(1);
                end
                if (pop[s])
                    rd_q[s] <= rd_q[s] + PW'(1);
            end
            seq_q <= seq_d;
            we_q  <= we_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
        end
    end

    assign bus.alu_ready = rdy[0];
    assign bus.mem_ready = rdy[1];
    assign bus.we        = we_q;
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.hazard    = haz;
    assign bus.busy      = we_q | (|head_v);
endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: directed stimulus with an acceptance-order scoreboard
// and a negedge monitor on the register-file write port.
module tb_regwb_arbiter;
    localparam int DW = 32;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regwb_arbiter_if #(.DW(DW)) bus();

    regwb_arbiter #(.DW(DW), .QDEPTH(QD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int            src;
        logic [3:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t mq[$];
    wr_t exp_q[$];
    wr_t wlog[$];
    int  mcnt[2];
    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;
    bit  a_acc, m_acc;
    wr_t me, ne, oe;

    logic [DW-1:0] bp_exp[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit av, input logic [3:0] aa,
                        input logic [31:0] ad, input bit mv,
                        input logic [3:0] ma, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Reference ordering: one pop of the oldest pending entry per edge,
    // then this edge's accepts appended ALU-first.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            exp_q.delete();
            mcnt[0] = 0;
            mcnt[1] = 0;
        end else begin
            a_acc = bus.alu_valid && (mcnt[0] < QD);
            m_acc = bus.mem_valid && (mcnt[1] < QD);
            if (mq.size() > 0) begin
                me = mq.pop_front();
                mcnt[me.src]--;
                exp_q.push_back(me);
            end
            if (a_acc) begin
                ne.src = 0; ne.addr = bus.alu_addr; ne.data = bus.alu_data;
                mq.push_back(ne);
                mcnt[0]++;
            end
            if (m_acc) begin
                ne.src = 1; ne.addr = bus.mem_addr; ne.data = bus.mem_data;
                mq.push_back(ne);
                mcnt[1]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.we === 1'b1) begin
                oe.src = 0; oe.addr = bus.wa; oe.data = bus.wd;
                wlog.push_back(oe);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got wa=%0d wd=%0h, required no write",
                             bus.wa, bus.wd);
                end else begin
                    me = exp_q.pop_front();
                    chk("write_wa", 64'(bus.wa), 64'(me.addr));
                    chk("write_wd", 64'(bus.wd), 64'(me.data));
                end
            end else if (exp_q.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL missing_write: got we=%b, required 1", bus.we);
                exp_q.delete();
            end
            chk("alu_ready", 64'(bus.alu_ready), 64'(mcnt[0] < QD));
            chk("mem_ready", 64'(bus.mem_ready), 64'(mcnt[1] < QD));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_addr1 = 0;
        bus.rd_addr2 = 0;
        bp_exp = '{32'hA0, 32'h100, 32'hA1, 32'h101,
                   32'hA2, 32'h103, 32'h105, 32'h107};

        // reset held with both producers requesting
        reset = 1'b1;
        step(1, 4'h7, 32'h77, 1, 4'h8, 32'h88);
        step(1, 4'h7, 32'h77, 1, 4'h8, 32'h88);
        chk("rst_we", 64'(bus.we), 64'(0));
        chk("rst_wa", 64'(bus.wa), 64'(0));
        chk("rst_wd", 64'(bus.wd), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        reset = 1'b0;
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'(1));
        chk("rst_mem_ready", 64'(bus.mem_ready), 64'(1));
        chk_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr1 = 4'(i);
            bus.rd_addr2 = 4'(i);
            step(0, 0, 0, 0, 0, 0);
            chk("rst_hazard", 64'(bus.hazard), 64'(0));
        end
        chk("rst_no_accept", 64'(wlog.size()), 64'(0));

        // single write and hazard window
        bus.rd_addr1 = 4'd3;
        bus.rd_addr2 = 4'd0;
        step(1, 4'd3, 32'hDEADBEEF, 0, 0, 0);
        chk("single_we0", 64'(bus.we), 64'(0));
        chk("single_haz_q", 64'(bus.hazard), 64'(1));
        chk("single_busy", 64'(bus.busy), 64'(1));
        idle(1);
        chk("single_we1", 64'(bus.we), 64'(1));
        chk("single_wa", 64'(bus.wa), 64'(3));
        chk("single_wd", 64'(bus.wd), 64'(32'hDEADBEEF));
        chk("single_haz_we", 64'(bus.hazard), 64'(1));
        idle(1);
        chk("single_we2", 64'(bus.we), 64'(0));
        chk("single_haz_end", 64'(bus.hazard), 64'(0));
        chk("single_idle", 64'(bus.busy), 64'(0));

        // r15 on the second read port
        bus.rd_addr1 = 4'd0;
        bus.rd_addr2 = 4'd15;
        step(0, 0, 0, 1, 4'd15, 32'h55);
        chk("r15_haz_q", 64'(bus.hazard), 64'(1));
        idle(1);
        chk("r15_wa", 64'(bus.wa), 64'(15));
        chk("r15_haz_we", 64'(bus.hazard), 64'(1));
        idle(1);
        chk("r15_haz_end", 64'(bus.hazard), 64'(0));

        // same-cycle collision on r5
        wlog.delete();
        step(1, 4'd5, 32'h1, 1, 4'd5, 32'h2);
        idle(3);
        chk("coll_count", 64'(wlog.size()), 64'(2));
        if (wlog.size() >= 2) begin
            chk("coll_first", 64'(wlog[0].data), 64'(1));
            chk("coll_second", 64'(wlog[1].data), 64'(2));
            chk("coll_addr", 64'(wlog[1].addr), 64'(5));
        end

        // backpressure: load every cycle, ALU for four cycles
        wlog.delete();
        for (int i = 0; i < 8; i++) begin
            step(i < 4, 4'(i), 32'hA0 + i, 1, 4'(8 + i), 32'h100 + i);
            if (i == 1) begin
                chk("bp_alu_rdy1", 64'(bus.alu_ready), 64'(1));
                chk("bp_mem_rdy1", 64'(bus.mem_ready), 64'(0));
            end
            if (i == 2) begin
                chk("bp_alu_rdy2", 64'(bus.alu_ready), 64'(0));
                chk("bp_mem_rdy2", 64'(bus.mem_ready), 64'(1));
            end
        end
        idle(4);
        chk("bp_count", 64'(wlog.size()), 64'(8));
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            chk("bp_order", 64'(wlog[i].data), 64'(bp_exp[i]));

        // stamp wrap with alternating sources
        wlog.delete();
        for (int i = 0; i < 20; i++)
            step(i % 2 == 0, 4'(i), 32'h200 + i,
                 i % 2 == 1, 4'(i), 32'h200 + i);
        idle(3);
        chk("wrap_count", 64'(wlog.size()), 64'(20));
        for (int i = 0; i < 20 && i < wlog.size(); i++)
            chk("wrap_order", 64'(wlog[i].data), 64'(32'h200 + i));

        // reset with writes still queued
        step(1, 4'd1, 32'h301, 1, 4'd2, 32'h302);
        step(1, 4'd3, 32'h303, 0, 0, 0);
        reset = 1'b1;
        idle(1);
        wlog.delete();
        reset = 1'b0;
        bus.rd_addr1 = 4'd2;
        bus.rd_addr2 = 4'd3;
        idle(4);
        chk("midrst_writes", 64'(wlog.size()), 64'(0));
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_we", 64'(bus.we), 64'(0));
        chk("midrst_haz", 64'(bus.hazard), 64'(0));

        chk("drain", 64'(mq.size() + exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
